// File: rtl/exec_mdu.sv
// rtl/exec_mdu.sv - iterative RV M-extension multiply/divide unit, radix 2^BITS_PER_CYCLE
// Optional MDU_FAST_ZERO_EN: zero-operand cases finish one cycle after accept.
module exec_mdu #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_rd,
  input  logic             hold,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_res,
  output logic [TAG_W-1:0] out_rd,
  output logic             busy
);
  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam int MW    = XLEN + BITS_PER_CYCLE;
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] rd_q;
  logic             neg_q, sa_q, bz_q, fast_q;
  logic [XLEN-1:0]  d_q, hi_q, lo_q;
  logic [XLEN-1:0]  hi_n, lo_n, res_n;

  logic            is_div, sgn_a, sgn_b, neg_a, neg_b, fast_hit;
  logic [XLEN-1:0] abs_a, abs_b, fast_res;

  assign in_ready = (state == IDLE) && !hold && !flush;
  assign busy     = (state != IDLE);

  assign is_div = in_op[2];
  assign sgn_a  = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
  assign sgn_b  = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
  assign neg_a  = sgn_a && in_a[XLEN-1];
  assign neg_b  = sgn_b && in_b[XLEN-1];
  assign abs_a  = neg_a ? -in_a : in_a;
  assign abs_b  = neg_b ? -in_b : in_b;

`ifdef MDU_FAST_ZERO_EN
  assign fast_hit = is_div ? (in_b == '0) : ((in_a == '0) || (in_b == '0));
  assign fast_res = !is_div ? '0 : (in_op[1] ? in_a : '1);
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  // hi/lo hold {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
  logic [MW-1:0]   mac;
  logic [XLEN:0]   rsh;
  logic [XLEN-1:0] rr, qq;
  always_comb begin
    mac  = '0;
    rsh  = '0;
    rr   = hi_q;
    qq   = lo_q;
    hi_n = hi_q;
    lo_n = lo_q;
    if (op_q[2]) begin
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
        rsh = {rr, qq[XLEN-1]};
        qq  = {qq[XLEN-2:0], 1'b0};
        if (rsh >= {1'b0, d_q}) begin
          rsh   = rsh - {1'b0, d_q};
          qq[0] = 1'b1;
        end
        rr = rsh[XLEN-1:0];
      end
      hi_n = rr;
      lo_n = qq;
    end else begin
      mac = MW'(hi_q) + MW'(d_q) * MW'(lo_q[BITS_PER_CYCLE-1:0]);
      {hi_n, lo_n} = {mac, lo_q[XLEN-1:BITS_PER_CYCLE]};
    end
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem;
  assign prod   = {hi_n, lo_n};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = bz_q ? '1 : (neg_q ? -lo_n : lo_n);
  assign rem    = sa_q ? -hi_n : hi_n;

  always_comb begin
    if (op_q[2])                res_n = op_q[1] ? rem : quo;
    else if (op_q[1:0] == 2'd0) res_n = prod_s[XLEN-1:0];
    else                        res_n = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      sa_q      <= 1'b0;
      bz_q      <= 1'b0;
      fast_q    <= 1'b0;
      d_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_rd    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (!hold) begin
      case (state)
        IDLE: if (in_valid) begin
          state  <= CALC;
          op_q   <= in_op;
          rd_q   <= in_rd;
          neg_q  <= neg_a ^ neg_b;
          sa_q   <= neg_a;
          bz_q   <= (in_b == '0);
          fast_q <= fast_hit;
          cnt    <= fast_hit ? CNT_W'(1) : CNT_W'(STEPS);
          d_q    <= is_div ? abs_b : abs_a;
          hi_q   <= '0;
          lo_q   <= fast_hit ? fast_res : (is_div ? abs_a : abs_b);
        end
        CALC: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_res   <= fast_q ? lo_q : res_n;
            out_rd    <= rd_q;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
